// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one shift per clock).
// Start/busy/done handshake; the registered result holds until the next completion.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = WIDTH + BW + 1;

    // 10^DIGITS < 16^DIGITS, so PW bits hold both sides of the comparison
    function automatic logic digits_ok();
        logic [PW-1:0] p10;
        logic [PW-1:0] maxv;
        p10  = PW'(1);
        maxv = {{(PW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
        for (int unsigned i = 0; i < DIGITS; i++) begin
            p10 = p10 * PW'(10);
        end
        return p10 > maxv;
    endfunction

    if (WIDTH < 1) begin : g_width_chk
        $error("bin_to_bcd_seq: WIDTH must be >= 1");
    end
    if (!digits_ok()) begin : g_digits_chk
        $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              done_q, done_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;
    logic                unused_adj_msb;

    always_comb begin
        adj = scratch_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // After adjustment the top digit is at most 12, so its MSB only feeds a bit that falls off
    assign shifted        = {adj[BW-2:0], shreg_q, 1'b0};
    assign unused_adj_msb = adj[BW-1];

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[BW+WIDTH-1:WIDTH];
                shreg_d   = shifted[WIDTH-1:0];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted[BW+WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a decimal-arithmetic transaction model checked every cycle,
// plus directed vectors with literal expected results.
module tb_bin_to_bcd_seq;

    localparam int W = 8;
    localparam int D = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  bin = '0;
    logic          busy;
    logic          done;
    logic [4*D-1:0] bcd;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r = '0;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    function automatic logic [3:0] excess3(input logic [3:0] d);
        return d + 4'd3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a conversion takes WIDTH cycles, then the decimal value appears with done
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_cnt  = 0;
    int          m_val  = 0;
    logic [11:0] m_bcd  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            m_bcd  = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_bcd  = to_bcd(m_val);
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_cnt  = W;
                m_val  = int'(bin);
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_done", 32'(done), 32'(m_done));
        check("cyc_bcd",  32'(bcd),  32'(m_bcd));
    end

    task automatic wait_done(output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
        end
    endtask

    task automatic run(input logic [W-1:0] v, input logic [11:0] exp, input bit ex3);
        int lat;
        int nb;
        bit seen;
        @(posedge clk); #1;
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = ~v;
        seen = 1'b0;
        lat  = 0;
        nb   = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
            else if (busy) nb++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got no done expected done for bin=%0d", v);
        end else begin
            check("latency", 32'(lat), 32'(W + 1));
            check("busy_cycles", 32'(nb), 32'(W));
            check("result", 32'(bcd), 32'(exp));
            if (ex3) begin
                for (int k = 0; k < D; k++) begin
                    logic [3:0] dd;
                    dd = bcd[4*k +: 4];
                    check("excess3", 32'(excess3(dd)), 32'(exp[4*k +: 4] + 4'd3));
                    check("digit_range", 32'(dd <= 4'd9), 32'(1));
                end
            end
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'(0));
        end
    endtask

    initial begin
        int lat;
        int nd;
        bit seen;

        // model pins
        check("model_0",   32'(to_bcd(0)),   32'(12'h000));
        check("model_255", 32'(to_bcd(255)), 32'(12'h255));
        check("model_99",  32'(to_bcd(99)),  32'(12'h099));
        check("model_ex3", 32'(excess3(4'd9)), 32'(4'hC));

        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_bcd",  32'(bcd),  32'(0));
        rst_n = 1'b1;

        run(8'd0,   12'h000, 1'b0);
        run(8'd255, 12'h255, 1'b0);
        run(8'd99,  12'h099, 1'b0);
        run(8'd10,  12'h010, 1'b0);

        // back-to-back: start issued during the done cycle
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, seen);
        check("b2b_first", 32'(bcd), 32'(12'h009));
        start = 1'b1;
        bin   = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 8'd1;
        wait_done(lat, seen);
        check("b2b_gap", 32'(lat), 32'(W + 1));
        check("b2b_second", 32'(bcd), 32'(12'h200));

        // start while busy is ignored
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 8'd123;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        bin   = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, seen);
        check("ignore_result", 32'(bcd), 32'(12'h123));
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("ignore_single_done", 32'(nd), 32'(0));
        check("ignore_hold", 32'(bcd), 32'(12'h123));

        // asynchronous reset mid-conversion
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 8'd77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_bcd",  32'(bcd),  32'(0));
        #4;
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("arst_no_done", 32'(nd), 32'(0));
        run(8'd77, 12'h077, 1'b0);

        // start held high: a new conversion every WIDTH+1 cycles
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 8'd42;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("held_start_dones", 32'(nd), 32'(3));
        repeat (15) @(negedge clk);
        check("held_start_result", 32'(bcd), 32'(12'h042));

        for (int v = 0; v < 256; v++) begin
            run(8'(v), to_bcd(v), 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finish");
        $fatal(1, "timeout");
    end

endmodule
